ts_access_scheduler: RTL and testbench

Single-port access scheduler for the 16x16 time-surface store. It multiplexes three requesters onto one memory port, one operation per cycle: decoded-event timestamp writes, feature-extractor scan reads, and a full-array clear sweep. Writes are buffered and rate-bounded so a busy event stream cannot starve the classifier's frame scan. It sits between the EVT 2.0 decoder / feature extractor and the time-surface BRAM.

---
 rtl/ts_access_scheduler_if.sv | 48 ++++
 rtl/ts_access_scheduler.sv | 158 +++++++++++++++
 tb/tb_ts_access_scheduler.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_access_scheduler_if.sv
// ts_access_scheduler_if: event, scan-read, clear and memory-port
// signals of the time-surface access scheduler.
interface ts_access_scheduler_if #(
  parameter int ADDR_BITS = 8,
  parameter int TS_BITS   = 16
);
  logic                 evt_valid;
  logic                 evt_ready;
  logic [ADDR_BITS-1:0] evt_addr;
  logic [TS_BITS-1:0]   evt_ts;

  logic                 rd_req;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 rd_gnt;
  logic                 rd_data_valid;
  logic [TS_BITS-1:0]   rd_data;

  logic                 clear_req;
  logic                 clear_busy;

  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [TS_BITS-1:0]   mem_wdata;
  logic [TS_BITS-1:0]   mem_rdata;

  modport slave (
    input  evt_valid, evt_addr, evt_ts,
    input  rd_req, rd_addr,
    input  clear_req,
    input  mem_rdata,
    output evt_ready,
    output rd_gnt, rd_data_valid, rd_data,
    output clear_busy,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output evt_valid, evt_addr, evt_ts,
    output rd_req, rd_addr,
    output clear_req,
    output mem_rdata,
    input  evt_ready,
    input  rd_gnt, rd_data_valid, rd_data,
    input  clear_busy,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ts_access_scheduler.sv
// ts_access_scheduler: single-port arbiter for the time-surface store.
// Buffered event writes, bounded write bursts, scan reads, clear sweep.
module ts_access_scheduler #(
  parameter int ADDR_BITS     = 8,
  parameter int TS_BITS       = 16,
  parameter int EVT_BUF_DEPTH = 4,
  parameter int MAX_WR_BURST  = 4
) (
  input logic                   clk,
  input logic                   rst,
  ts_access_scheduler_if.slave  bus
);

  localparam int PW = $clog2(EVT_BUF_DEPTH);
  localparam int SW = $clog2(MAX_WR_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_WR_BURST);

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [TS_BITS-1:0]   ts;
  } evt_t;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] clr_ptr;
  logic [SW-1:0]        streak;

  evt_t                 buf_q [EVT_BUF_DEPTH];
  logic [PW:0]          wr_ptr;
  logic [PW:0]          rd_ptr;
  evt_t                 head;

  logic                 empty;
  logic                 full;
  logic                 streak_max;
  logic                 clearing;
  logic                 in_idle;
  logic                 push;
  logic                 do_wr;
  logic                 do_rd;

  logic                 rd_dv_q;
  logic [TS_BITS-1:0]   rd_hold;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = buf_q[rd_ptr[PW-1:0]];

  assign streak_max = streak == STREAK_MAX;
  assign clearing   = !rst && state == S_CLEAR;
  assign in_idle    = !rst && state == S_IDLE;

  // reads win only once the buffer is drained or the burst cap is hit
  assign do_wr = in_idle && !empty &&
                 (!bus.rd_req || !streak_max);
  assign do_rd = in_idle && bus.rd_req &&
                 (empty || streak_max);

  assign bus.evt_ready  = !rst && !full && !clearing;
  assign push           = bus.evt_valid && bus.evt_ready;
  assign bus.rd_gnt     = do_rd;
  assign bus.clear_busy = clearing;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      clearing: begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = clr_ptr;
      end
      do_wr: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = head.addr;
        bus.mem_wdata = head.ts;
      end
      do_rd: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.rd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      clr_ptr <= '0;
      streak  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (do_wr) begin
            streak <= streak_max ? streak : streak + SW'(1);
          end else begin
            streak <= '0;
          end
          if (bus.clear_req) begin
            state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_BITS'(1);
          streak  <= '0;
          if (clr_ptr == '1) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (PW+1)'(1);
      end
      if (do_wr) begin
        rd_ptr <= rd_ptr + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr[PW-1:0]] <= '{addr: bus.evt_addr, ts: bus.evt_ts};
    end
  end

  // rd_data is the live memory word in the valid cycle, held afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dv_q <= 1'b0;
      rd_hold <= '0;
    end else begin
      rd_dv_q <= do_rd;
      if (rd_dv_q) begin
        rd_hold <= bus.mem_rdata;
      end
    end
  end

  assign bus.rd_data_valid = rd_dv_q;
  assign bus.rd_data       = rd_dv_q ? bus.mem_rdata : rd_hold;

endmodule

// File: tb/tb_ts_access_scheduler.sv
// tb_ts_access_scheduler: directed vector tables plus hand-written
// sequences for sweep, reset-abort and buffer-full corner cases.
module tb_ts_access_scheduler;

  localparam int AB = 8;
  localparam int TB = 16;
  localparam int ID = 0;
  localparam int WR = 1;
  localparam int RD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ts_access_scheduler_if #(.ADDR_BITS(AB), .TS_BITS(TB)) bus ();

  ts_access_scheduler #(
    .ADDR_BITS(AB),
    .TS_BITS(TB),
    .EVT_BUF_DEPTH(4),
    .MAX_WR_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [15:0] mem [256];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    logic        ev;
    logic [7:0]  ea;
    logic [15:0] et;
    logic        rr;
    logic [7:0]  ra;
    logic        cr;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   errs = 0;
  int   checks = 0;

  function automatic logic [63:0] pk(
    logic rdy, logic gnt, logic dv, logic busy,
    logic en, logic we, logic [7:0] a,
    logic [15:0] wd, logic [15:0] rd);
    return {18'd0, rdy, gnt, dv, busy, en, we, a, wd, rd};
  endfunction

  function automatic logic [63:0] outs();
    return pk(bus.evt_ready, bus.rd_gnt, bus.rd_data_valid,
              bus.clear_busy, bus.mem_en, bus.mem_we,
              bus.mem_addr, bus.mem_wdata, bus.rd_data);
  endfunction

  function automatic vec_t mk(
    logic ev, logic [7:0] ea, logic [15:0] et,
    logic rr, logic [7:0] ra, logic cr,
    logic rdy, logic dv, logic [15:0] rd,
    int op, logic [7:0] oa, logic [15:0] od);
    vec_t v;
    v.ev = ev; v.ea = ea; v.et = et;
    v.rr = rr; v.ra = ra; v.cr = cr;
    v.exp = pk(rdy, op == RD, dv, 1'b0, op != ID, op == WR,
               (op == ID) ? 8'h00 : oa,
               (op == WR) ? od : 16'h0000, rd);
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic ev, logic [7:0] ea, logic [15:0] et,
                       logic rr, logic [7:0] ra, logic cr);
    bus.evt_valid = ev;
    bus.evt_addr  = ea;
    bus.evt_ts    = et;
    bus.rd_req    = rr;
    bus.rd_addr   = ra;
    bus.clear_req = cr;
  endtask

  task automatic run_tbl(string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].ev, tbl[i].ea, tbl[i].et,
            tbl[i].rr, tbl[i].ra, tbl[i].cr);
      #1;
      chk($sformatf("%s[%0d]", nm, i), outs(), tbl[i].exp);
    end
    tbl.delete();
  endtask

  initial begin
    logic [63:0] act;
    logic [23:0] q[$];
    int n;
    int wr_run;
    logic saw_full;
    logic active;
    logic exp_rdy;

    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    bus.mem_rdata = '0;
    drive(1'b1, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b0);

    // reset values with requests pending
    repeat (3) @(negedge clk);
    #1;
    act = outs();
    act[45] = 1'b0;
    chk("reset", act, pk(0, 0, 0, 0, 0, 0, 8'h00, 16'h0, 16'h0));

    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
    #1;
    chk("post_reset", outs(), pk(1, 0, 0, 0, 0, 0, 8'h00, 16'h0, 16'h0));

    // back-to-back scan of the whole array: 256 reads in 257 cycles
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      drive(1'b0, 8'h00, 16'h0000, i < 256, 8'(i), 1'b0);
      #1;
      if (i < 256)
        chk("scan_gnt",
            {bus.rd_gnt, bus.mem_en, bus.mem_we, bus.mem_addr},
            {1'b1, 1'b1, 1'b0, 8'(i)});
      if (i > 0)
        chk("scan_data", {bus.rd_data_valid, bus.rd_data},
            {1'b1, 16'h1000 + 16'(i - 1)});
      else
        chk("scan_dv0", {63'd0, bus.rd_data_valid}, 64'd0);
    end

    // single read, three in-order writes, burst cap with read pending
    tbl.push_back(mk(0, 8'h00, 16'h0000, 1, 8'hA0, 0, 1, 0, 16'h10FF, RD, 8'hA0, 0));
    tbl.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 1, 16'h10A0, ID, 0, 0));
    tbl.push_back(mk(1, 8'h11, 16'h0100, 0, 8'h00, 0, 1, 0, 16'h10A0, ID, 0, 0));
    tbl.push_back(mk(1, 8'h22, 16'h0101, 0, 8'h00, 0, 1, 0, 16'h10A0, WR, 8'h11, 16'h0100));
    tbl.push_back(mk(1, 8'h33, 16'h0102, 0, 8'h00, 0, 1, 0, 16'h10A0, WR, 8'h22, 16'h0101));
    tbl.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 16'h10A0, WR, 8'h33, 16'h0102));
    tbl.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 16'h10A0, ID, 0, 0));
    tbl.push_back(mk(1, 8'h05, 16'h0200, 0, 8'h00, 0, 1, 0, 16'h10A0, ID, 0, 0));
    tbl.push_back(mk(1, 8'h41, 16'h0201, 1, 8'h05, 0, 1, 0, 16'h10A0, WR, 8'h05, 16'h0200));
    tbl.push_back(mk(1, 8'h42, 16'h0202, 1, 8'h05, 0, 1, 0, 16'h10A0, WR, 8'h41, 16'h0201));
    tbl.push_back(mk(1, 8'h43, 16'h0203, 1, 8'h05, 0, 1, 0, 16'h10A0, WR, 8'h42, 16'h0202));
    tbl.push_back(mk(1, 8'h44, 16'h0204, 1, 8'h05, 0, 1, 0, 16'h10A0, WR, 8'h43, 16'h0203));
    tbl.push_back(mk(1, 8'h45, 16'h0205, 1, 8'h05, 0, 1, 0, 16'h10A0, RD, 8'h05, 0));
    tbl.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 1, 16'h0200, WR, 8'h44, 16'h0204));
    tbl.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 16'h0200, WR, 8'h45, 16'h0205));
    tbl.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 16'h0200, ID, 0, 0));
    run_tbl("basic");

    // leave two events buffered when the clear is requested
    tbl.push_back(mk(1, 8'h60, 16'h0300, 1, 8'h77, 0, 1, 0, 16'h0200, RD, 8'h77, 0));
    tbl.push_back(mk(1, 8'h61, 16'h0301, 1, 8'h77, 0, 1, 1, 16'h1077, WR, 8'h60, 16'h0300));
    tbl.push_back(mk(1, 8'h62, 16'h0302, 1, 8'h77, 0, 1, 0, 16'h1077, WR, 8'h61, 16'h0301));
    tbl.push_back(mk(1, 8'h63, 16'h0303, 1, 8'h77, 0, 1, 0, 16'h1077, WR, 8'h62, 16'h0302));
    tbl.push_back(mk(1, 8'h64, 16'h0304, 1, 8'h77, 0, 1, 0, 16'h1077, WR, 8'h63, 16'h0303));
    tbl.push_back(mk(1, 8'h65, 16'h0305, 1, 8'h77, 1, 1, 0, 16'h1077, RD, 8'h77, 0));
    run_tbl("pre_clear");

    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      drive(1'b1, 8'h99, 16'hDEAD, 1'b1, 8'h00, k == 8);
      #1;
      chk($sformatf("sweep[%0d]", k), outs(),
          pk(0, 0, k == 0, 1, 1, 1, 8'(k), 16'h0, 16'h1077));
    end

    tbl.push_back(mk(0, 8'h00, 16'h0000, 1, 8'h00, 0, 1, 0, 16'h1077, WR, 8'h64, 16'h0304));
    tbl.push_back(mk(0, 8'h00, 16'h0000, 1, 8'h00, 0, 1, 0, 16'h1077, WR, 8'h65, 16'h0305));
    tbl.push_back(mk(0, 8'h00, 16'h0000, 1, 8'h00, 0, 1, 0, 16'h1077, RD, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 1, 16'h0000, ID, 0, 0));
    tbl.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 0, 16'h0000, ID, 0, 0));
    tbl.push_back(mk(1, 8'h70, 16'h0400, 0, 8'h00, 1, 1, 0, 16'h0000, ID, 0, 0));
    run_tbl("post_clear");

    // reset lands at sweep address 0x40
    for (int k = 0; k <= 8'h40; k++) begin
      @(negedge clk);
      drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, k == 5);
      rst = (k == 8'h40);
      #1;
      if (k < 8'h40)
        chk($sformatf("sweep2[%0d]", k), outs(),
            pk(0, 0, 0, 1, 1, 1, 8'(k), 16'h0, 16'h0));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
      #1;
      chk($sformatf("abort[%0d]", k), outs(),
          pk(1, 0, 0, 0, 0, 0, 8'h00, 16'h0, 16'h0));
    end
    tbl.push_back(mk(0, 8'h00, 16'h0000, 1, 8'h00, 0, 1, 0, 16'h0000, RD, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 1, 16'h0000, ID, 0, 0));
    run_tbl("after_abort");

    // sustained events with a read held: buffer must fill, no event lost
    n = 0;
    wr_run = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      active = c < 40;
      drive(active, 8'h80 + 8'(n), 16'h0500 + 16'(n),
            active, 8'h10, 1'b0);
      #1;
      exp_rdy = q.size() < 4;
      chk("fill_rdy", {63'd0, bus.evt_ready}, {63'd0, exp_rdy});
      if (!bus.evt_ready) saw_full = 1'b1;
      if (bus.mem_en && bus.mem_we) begin
        if (q.size() == 0) begin
          chk("fill_wr_empty", 64'(q.size()), 64'd1);
        end else begin
          chk("fill_wr", {40'd0, bus.mem_addr, bus.mem_wdata},
              {40'd0, q[0]});
          void'(q.pop_front());
        end
        if (active) begin
          wr_run++;
          chk("fill_burst", {63'd0, wr_run > 4}, 64'd0);
        end
      end
      if (bus.rd_gnt) begin
        if (q.size() > 0) chk("fill_fair", 64'(wr_run), 64'd4);
        wr_run = 0;
      end
      if (bus.evt_valid && bus.evt_ready) begin
        q.push_back({8'h80 + 8'(n), 16'h0500 + 16'(n)});
        n++;
      end
    end
    chk("fill_drained", 64'(q.size()), 64'd0);
    chk("fill_saw_full", {63'd0, saw_full}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
